// File: rtl/iris_feature_booleanizer.sv
// Serial-in booleanizer for the Iris Tsetlin Machine: thresholds one raw feature per beat
// and hands a packed boolean vector to clause evaluation over valid/ready.
//
// state   | meaning
// COLLECT | accepting beats, building the vector in acc
// HOLD    | vector presented on features/out_valid, upstream stalled
// DISCARD | sample overran NUM_FEATURES; dropping beats through in_last
module iris_feature_booleanizer #(
  parameter int NUM_FEATURES = 2,
  parameter int DATA_W = 8,
  parameter logic [NUM_FEATURES*DATA_W-1:0] THRESHOLDS = 16'h0819,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic [NUM_FEATURES-1:0] features,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    frame_err,
  output logic [CNT_W-1:0]        sample_count
);

  localparam int IDX_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

  typedef enum logic [1:0] {COLLECT, HOLD, DISCARD} state_t;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic [NUM_FEATURES-1:0] acc, acc_nxt, merged, features_nxt;
  logic                    out_valid_nxt, in_ready_nxt, frame_err_nxt;
  logic [CNT_W-1:0]        count_nxt;
  logic [DATA_W-1:0]       thr;
  logic                    bit_val, beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= COLLECT;
      idx          <= '0;
      acc          <= '0;
      features     <= '0;
      out_valid    <= 1'b0;
      in_ready     <= 1'b0;
      frame_err    <= 1'b0;
      sample_count <= '0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      acc          <= acc_nxt;
      features     <= features_nxt;
      out_valid    <= out_valid_nxt;
      in_ready     <= in_ready_nxt;
      frame_err    <= frame_err_nxt;
      sample_count <= count_nxt;
    end
  end

  // merged is acc with the current beat's bit already in place, so the final beat
  // can be published the same edge it arrives
  always_comb begin
    thr    = '0;
    merged = acc;
    for (int i = 0; i < NUM_FEATURES; i++) begin
      if (idx == IDX_W'(i)) thr = THRESHOLDS[i*DATA_W +: DATA_W];
    end
    bit_val = (in_data >= thr);
    for (int i = 0; i < NUM_FEATURES; i++) begin
      if (idx == IDX_W'(i)) merged[i] = bit_val;
    end
    beat = in_valid && in_ready;
  end

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    acc_nxt       = acc;
    features_nxt  = features;
    out_valid_nxt = out_valid;
    in_ready_nxt  = in_ready;
    frame_err_nxt = 1'b0;
    count_nxt     = sample_count;
    case (state)
      COLLECT: begin
        in_ready_nxt = 1'b1;
        if (beat) begin
          acc_nxt = merged;
          if (idx != LAST_IDX) begin
            if (!in_last) begin
              idx_nxt = idx + 1'b1;
            end else begin
              frame_err_nxt = 1'b1;
              acc_nxt       = '0;
              idx_nxt       = '0;
            end
          end else if (in_last) begin
            features_nxt  = merged;
            out_valid_nxt = 1'b1;
            in_ready_nxt  = 1'b0;
            acc_nxt       = '0;
            idx_nxt       = '0;
            state_nxt     = HOLD;
          end else begin
            frame_err_nxt = 1'b1;
            acc_nxt       = '0;
            idx_nxt       = '0;
            state_nxt     = DISCARD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          in_ready_nxt  = 1'b1;
          count_nxt     = sample_count + 1'b1;
          state_nxt     = COLLECT;
        end
      end
      DISCARD: begin
        in_ready_nxt = 1'b1;
        if (beat && in_last) begin
          idx_nxt   = '0;
          state_nxt = COLLECT;
        end
      end
      default: begin
        state_nxt = COLLECT;
        idx_nxt   = '0;
        acc_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_iris_feature_booleanizer.sv
// Directed bench for iris_feature_booleanizer; delivered vectors are checked against
// a queue of expected values pushed as each sample is driven.
`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) passes++; else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); end

module tb_iris_feature_booleanizer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid, in_last, in_ready;
  logic [1:0] features;
  logic       out_valid, out_ready, frame_err;
  logic [15:0] sample_count;

  logic [7:0] w_in_data;
  logic       w_in_valid, w_in_last, w_in_ready;
  logic [1:0] w_features;
  logic       w_out_valid, w_frame_err;
  logic [2:0] w_count;

  int checks = 0;
  int passes = 0;
  int delivered = 0;
  int frame_errs = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  iris_feature_booleanizer dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .features(features), .out_valid(out_valid), .out_ready(out_ready),
    .frame_err(frame_err), .sample_count(sample_count)
  );

  // Narrow counter instance so the wrap can be observed in a few samples
  iris_feature_booleanizer #(.CNT_W(3)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_data(w_in_data), .in_valid(w_in_valid), .in_last(w_in_last),
    .in_ready(w_in_ready), .features(w_features), .out_valid(w_out_valid), .out_ready(1'b1),
    .frame_err(w_frame_err), .sample_count(w_count)
  );

  function automatic logic [1:0] bools(input int d0, input int d1);
    return {(d1 >= 8) ? 1'b1 : 1'b0, (d0 >= 25) ? 1'b1 : 1'b0};
  endfunction

  always @(negedge clk) begin
    if (rst_n && frame_err) frame_errs++;
    if (rst_n && out_valid && out_ready) begin
      `CHK("queue_has_expected", (exp_q.size() > 0), 1'b1)
      if (exp_q.size() > 0) begin
        logic [1:0] e;
        e = exp_q.pop_front();
        `CHK("features", features, e)
      end
      delivered++;
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    in_data = d; in_last = l; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready || n > 50) break;
      n++;
    end
    `CHK("beat_accept_timeout", (n <= 50), 1'b1)
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_sample(input int d0, input int d1);
    exp_q.push_back(bools(d0, d1));
    send_beat(8'(d0), 1'b0);
    send_beat(8'(d1), 1'b1);
  endtask

  task automatic wait_delivered(input int target);
    int n;
    n = 0;
    while (delivered < target && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    `CHK("delivery_timeout", (delivered >= target), 1'b1)
  endtask

  task automatic send_beat_w(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    w_in_data = d; w_in_last = l; w_in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (w_in_ready || n > 50) break;
      n++;
    end
    `CHK("w_beat_accept_timeout", (n <= 50), 1'b1)
    @(posedge clk); #1;
    w_in_valid = 1'b0; w_in_last = 1'b0;
  endtask

  initial begin
    int d_before, fe_before;
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    w_in_data = '0; w_in_valid = 1'b0; w_in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    `CHK("rst_in_ready", in_ready, 1'b0)
    `CHK("rst_out_valid", out_valid, 1'b0)
    `CHK("rst_features", features, 2'b00)
    `CHK("rst_frame_err", frame_err, 1'b0)
    `CHK("rst_sample_count", sample_count, 16'd0)
    rst_n = 1'b1;
    #1;
    `CHK("in_ready_before_edge", in_ready, 1'b0)
    @(posedge clk); #1;
    `CHK("in_ready_after_release", in_ready, 1'b1)

    // First sample with latency and handshake timing
    out_ready = 1'b1;
    exp_q.push_back(bools(30, 9));
    send_beat(8'd30, 1'b0);
    send_beat(8'd9, 1'b1);
    `CHK("lat_out_valid", out_valid, 1'b1)
    `CHK("lat_features", features, 2'b11)
    `CHK("lat_in_ready_low", in_ready, 1'b0)
    @(posedge clk); #1;
    `CHK("hs_out_valid_drop", out_valid, 1'b0)
    `CHK("hs_in_ready_back", in_ready, 1'b1)
    `CHK("hs_sample_count", sample_count, 16'd1)

    send_sample(25, 7);
    send_sample(24, 8);
    wait_delivered(3);
    `CHK("count_after_3", sample_count, 16'd3)

    // Backpressure: vector held while upstream keeps offering data
    out_ready = 1'b0;
    exp_q.push_back(bools(30, 9));
    send_beat(8'd30, 1'b0);
    send_beat(8'd9, 1'b1);
    in_data = 8'd40; in_last = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      `CHK("hold_out_valid", out_valid, 1'b1)
      `CHK("hold_features", features, 2'b11)
      `CHK("hold_in_ready", in_ready, 1'b0)
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    `CHK("hold_release_in_ready", in_ready, 1'b1)
    `CHK("hold_release_out_valid", out_valid, 1'b0)
    exp_q.push_back(bools(40, 3));
    send_beat(8'd40, 1'b0);
    send_beat(8'd3, 1'b1);
    wait_delivered(5);

    // Short sample
    d_before = delivered;
    fe_before = frame_errs;
    send_beat(8'd30, 1'b1);
    `CHK("short_frame_err", frame_err, 1'b1)
    `CHK("short_no_out_valid", out_valid, 1'b0)
    @(posedge clk); #1;
    `CHK("short_frame_err_1cyc", frame_err, 1'b0)
    `CHK("short_no_vector", delivered, d_before)
    send_sample(10, 20);
    wait_delivered(d_before + 1);

    // Long sample
    d_before = delivered;
    send_beat(8'd30, 1'b0);
    send_beat(8'd9, 1'b0);
    `CHK("long_frame_err", frame_err, 1'b1)
    send_beat(8'd50, 1'b0);
    `CHK("long_frame_err_once_a", frame_err, 1'b0)
    send_beat(8'd60, 1'b1);
    `CHK("long_frame_err_once_b", frame_err, 1'b0)
    `CHK("long_no_out_valid", out_valid, 1'b0)
    `CHK("frame_err_pulse_total", frame_errs - fe_before, 2)
    `CHK("long_no_vector", delivered, d_before)
    send_sample(26, 100);
    wait_delivered(d_before + 1);
    `CHK("count_before_reset", sample_count, 16'(delivered))

    // Asynchronous reset while holding a vector
    out_ready = 1'b0;
    send_beat(8'd30, 1'b0);
    send_beat(8'd9, 1'b1);
    `CHK("pre_reset_hold", out_valid, 1'b1)
    #2 rst_n = 1'b0;
    #1;
    `CHK("async_out_valid", out_valid, 1'b0)
    `CHK("async_features", features, 2'b00)
    `CHK("async_sample_count", sample_count, 16'd0)
    `CHK("async_in_ready", in_ready, 1'b0)
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Counter wrap on the 3-bit instance
    for (int s = 0; s < 7; s++) begin
      send_beat_w(8'(s * 7), 1'b0);
      send_beat_w(8'd5, 1'b1);
    end
    repeat (2) @(posedge clk);
    #1;
    `CHK("w_count_7", w_count, 3'd7)
    send_beat_w(8'd1, 1'b0);
    send_beat_w(8'd1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    `CHK("w_count_wrap", w_count, 3'd0)

    `CHK("queue_drained", exp_q.size(), 0)
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
